fma16_operand_stage: RTL and testbench

- Registered intake stage in front of the fma16 datapath and its result selector.
- Accepts one x/y/z/mul/add operation per valid/ready handshake. Classifies each operand into the four flags the downstream selector consumes: NonZero, NonInf, NonNan, Normal.
- Presents the operation plus flags through a 2-entry skid buffer, so backpressure from the datapath never creates a combinational path from out_ready to in_ready.

---
 rtl/fma16_pkg.sv | 25 ++
 rtl/fma16_operand_stage_if.sv | 33 +++
 rtl/fma16_classify.sv | 22 ++
 rtl/fma16_operand_stage.sv | 73 +++++++
 tb/tb_fma16_operand_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fma16_pkg.sv
// fma16_pkg: shared types and constants for the fma16 operand intake stage.
package fma16_pkg;
  localparam logic [4:0] EXP_MAX = 5'h1f;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_ONE = 16'h3C00;
  typedef struct packed {
    logic nonzero;
    logic noninf;
    logic nonnan;
    logic normal;
  } fp16_class_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic mul;
    logic add;
    fp16_class_t cx;
    fp16_class_t cy;
    fp16_class_t cz;
    logic prodsign;
  } entry_t;
endpackage

// File: rtl/fma16_operand_stage_if.sv
// fma16_operand_stage_if: upstream handshake, operands and downstream entry bus.
interface fma16_operand_stage_if;
  logic in_valid;
  logic in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic mul;
  logic add;
  logic out_valid;
  logic out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [15:0] out_z;
  logic out_mul;
  logic out_add;
  logic [2:0] out_nonzero;
  logic [2:0] out_noninf;
  logic [2:0] out_nonnan;
  logic [2:0] out_normal;
  logic out_prodsign;
  logic busy;
  modport master (
    output in_valid, x, y, z, mul, add, out_ready,
    input in_ready, out_valid, out_x, out_y, out_z, out_mul, out_add,
    input out_nonzero, out_noninf, out_nonnan, out_normal, out_prodsign, busy
  );
  modport slave (
    input in_valid, x, y, z, mul, add, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_mul, out_add,
    output out_nonzero, out_noninf, out_nonnan, out_normal, out_prodsign, busy
  );
endinterface

// File: rtl/fma16_classify.sv
// fma16_classify: binary16 operand class flags for the result selector.
module fma16_classify
  import fma16_pkg::*;
#(
  parameter bit FLUSH_SUBNORM = 1'b1
) (
  input  logic [15:0] a_i,
  output fp16_class_t c_o
);
  logic [4:0] e;
  logic fz;
  logic unused_sign;
  assign e = a_i[14:10];
  assign fz = a_i[9:0] == 10'd0;
  assign unused_sign = a_i[15];
  always_comb begin
    c_o.nonnan = !(e == EXP_MAX && !fz);
    c_o.noninf = !(e == EXP_MAX && fz);
    c_o.nonzero = (e != 5'd0) || (!FLUSH_SUBNORM && !fz);
    c_o.normal = (e != 5'd0) && (e != EXP_MAX);
  end
endmodule

// File: rtl/fma16_operand_stage.sv
// fma16_operand_stage: registered intake with operand classification and a 2-entry skid buffer.
module fma16_operand_stage
  import fma16_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter bit FLUSH_SUBNORM = 1'b1
) (
  input logic clk,
  input logic reset,
  fma16_operand_stage_if.slave bus
);
  if (DEPTH != 2) begin : g_depth_chk
    $error("fma16_operand_stage supports DEPTH=2 only");
  end
  occ_e state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, in_e;
  fp16_class_t cx, cy, cz;
  logic in_ready_q, acc, pop;
  fma16_classify #(.FLUSH_SUBNORM(FLUSH_SUBNORM)) u_cls_x (.a_i(bus.x), .c_o(cx));
  fma16_classify #(.FLUSH_SUBNORM(FLUSH_SUBNORM)) u_cls_y (.a_i(bus.y), .c_o(cy));
  fma16_classify #(.FLUSH_SUBNORM(FLUSH_SUBNORM)) u_cls_z (.a_i(bus.z), .c_o(cz));
  assign in_e = {bus.x, bus.y, bus.z, bus.mul, bus.add, cx, cy, cz, bus.x[15] ^ bus.y[15]};
  assign acc = bus.in_valid & in_ready_q;
  assign pop = (state_q != EMPTY) & bus.out_ready;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        head_d = in_e;
        state_d = ONE;
      end
      ONE: if (acc && pop) head_d = in_e;
      else if (acc) begin
        skid_d = in_e;
        state_d = FULL;
      end else if (pop) state_d = EMPTY;
      FULL: if (pop) begin
        head_d = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end
  // in_ready comes from next occupancy so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= state_d != FULL;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.busy = state_q != EMPTY;
  assign bus.out_x = head_q.x;
  assign bus.out_y = head_q.y;
  assign bus.out_z = head_q.z;
  assign bus.out_mul = head_q.mul;
  assign bus.out_add = head_q.add;
  assign bus.out_nonzero = {head_q.cx.nonzero, head_q.cy.nonzero, head_q.cz.nonzero};
  assign bus.out_noninf = {head_q.cx.noninf, head_q.cy.noninf, head_q.cz.noninf};
  assign bus.out_nonnan = {head_q.cx.nonnan, head_q.cy.nonnan, head_q.cz.nonnan};
  assign bus.out_normal = {head_q.cx.normal, head_q.cy.normal, head_q.cz.normal};
  assign bus.out_prodsign = head_q.prodsign;
endmodule

// File: tb/tb_fma16_operand_stage.sv
// tb_fma16_operand_stage: randomized self-checking bench against a FIFO reference model.
module tb_fma16_operand_stage;
  import fma16_pkg::*;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic mul;
    logic add;
  } op_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  op_t q[$];
  logic rdy_m = 1'b0;
  logic [62:0] obs;
  always #5 clk = ~clk;
  fma16_operand_stage_if bus();
  fma16_operand_stage #(.DEPTH(2), .FLUSH_SUBNORM(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  assign obs = {bus.out_x, bus.out_y, bus.out_z, bus.out_mul, bus.out_add, bus.out_nonzero,
                bus.out_noninf, bus.out_nonnan, bus.out_normal, bus.out_prodsign};
  // {nonzero, noninf, nonnan, normal} from exponent/fraction, subnormals flushed to zero
  function automatic logic [3:0] ref_cls(logic [15:0] v);
    int e = int'(v[14:10]);
    int f = int'(v[9:0]);
    return {e != 0, !(e == 31 && f == 0), !(e == 31 && f != 0), e > 0 && e < 31};
  endfunction
  function automatic logic [62:0] expect_out(op_t o);
    logic [3:0] a = ref_cls(o.x);
    logic [3:0] b = ref_cls(o.y);
    logic [3:0] c = ref_cls(o.z);
    return {o.x, o.y, o.z, o.mul, o.add, a[3], b[3], c[3], a[2], b[2], c[2],
            a[1], b[1], c[1], a[0], b[0], c[0], o.x[15] ^ o.y[15]};
  endfunction
  function automatic logic [15:0] rand_fp();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r[14:0] = 15'd0;
      1: begin r[14:10] = 5'd0; r[0] = 1'b1; end
      2: r[14:0] = FP16_POS_INF[14:0];
      3: begin r[14:10] = 5'h1f; r[9] = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction
  function automatic op_t rand_op();
    return {rand_fp(), rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
  endfunction
  task automatic step(input logic v, input op_t d, input logic ordy, output logic acc);
    logic pop;
    bus.in_valid = v;
    bus.x = d.x;
    bus.y = d.y;
    bus.z = d.z;
    bus.mul = d.mul;
    bus.add = d.add;
    bus.out_ready = ordy;
    acc = v & rdy_m;
    pop = (q.size() != 0) & ordy;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    rdy_m = q.size() != 2;
    #1;
  endtask
  task automatic test_reset();
    logic a;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    {bus.x, bus.y, bus.z, bus.mul, bus.add} = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    n_checks++; if (obs !== 63'd0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", obs); end
    reset = 1'b0;
    q.delete();
    rdy_m = 1'b0;
    step(1'b0, '0, 1'b0, a);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0 || obs !== 63'd0) begin n_fail++; $display("FAIL rst_idle got v=%b d=%h exp v=0 d=0", bus.out_valid, obs); end
  endtask
  task automatic test_basic();
    logic a;
    op_t o = {FP16_ONE, 16'h4000, 16'h0000, 1'b1, 1'b1};
    step(1'b1, o, 1'b1, a);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_x !== FP16_ONE) begin n_fail++; $display("FAIL basic_head got v=%b x=%h exp v=1 x=3c00", bus.out_valid, bus.out_x); end
    n_checks++; if (bus.out_normal !== 3'b110 || bus.out_nonzero !== 3'b110) begin n_fail++; $display("FAIL basic_norm_nz got %b %b exp 110 110", bus.out_normal, bus.out_nonzero); end
    n_checks++; if (bus.out_noninf !== 3'b111 || bus.out_nonnan !== 3'b111 || bus.out_prodsign !== 1'b0) begin n_fail++; $display("FAIL basic_inf_nan_sign got %b %b %b exp 111 111 0", bus.out_noninf, bus.out_nonnan, bus.out_prodsign); end
    n_checks++; if (obs !== expect_out(o)) begin n_fail++; $display("FAIL basic_entry got=%h exp=%h", obs, expect_out(o)); end
    step(1'b0, '0, 1'b1, a);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_drain got v=%b b=%b exp 0 0", bus.out_valid, bus.busy); end
  endtask
  task automatic test_special();
    logic a;
    op_t s0 = {FP16_QNAN, FP16_ONE, FP16_ONE, 1'b1, 1'b0};
    op_t s1 = {FP16_ONE, FP16_POS_INF | 16'h8000, FP16_ONE, 1'b1, 1'b0};
    op_t s2 = {FP16_ONE, FP16_ONE, 16'h0001, 1'b0, 1'b0};
    step(1'b1, s0, 1'b1, a);
    n_checks++; if (bus.out_nonnan[2] !== 1'b0 || obs !== expect_out(s0)) begin n_fail++; $display("FAIL special_nan got=%h exp=%h", obs, expect_out(s0)); end
    step(1'b1, s1, 1'b1, a);
    n_checks++; if (bus.out_noninf[1] !== 1'b0 || bus.out_prodsign !== 1'b1 || obs !== expect_out(s1)) begin n_fail++; $display("FAIL special_inf got=%h exp=%h", obs, expect_out(s1)); end
    step(1'b1, s2, 1'b1, a);
    n_checks++; if (bus.out_nonzero[0] !== 1'b0 || bus.out_normal[0] !== 1'b0 || obs !== expect_out(s2)) begin n_fail++; $display("FAIL special_subnorm got=%h exp=%h", obs, expect_out(s2)); end
    step(1'b0, '0, 1'b1, a);
  endtask
  task automatic test_backpressure();
    logic a;
    logic c_taken = 1'b0;
    int got = 0;
    op_t ops[3];
    foreach (ops[i]) ops[i] = rand_op();
    step(1'b1, ops[0], 1'b0, a);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got=%b exp=1", bus.in_ready); end
    step(1'b1, ops[1], 1'b0, a);
    n_checks++; if (bus.in_ready !== 1'b0 || obs !== expect_out(ops[0])) begin n_fail++; $display("FAIL bp_full got r=%b d=%h exp r=0 d=%h", bus.in_ready, obs, expect_out(ops[0])); end
    step(1'b1, ops[2], 1'b0, a);
    n_checks++; if (bus.in_ready !== 1'b0 || obs !== expect_out(ops[0])) begin n_fail++; $display("FAIL bp_c_refused got r=%b d=%h exp r=0 d=%h", bus.in_ready, obs, expect_out(ops[0])); end
    for (int i = 0; i < 6; i++) begin
      if (got < 3) begin
        n_checks++; if (bus.out_valid !== 1'b1 || obs !== expect_out(ops[got])) begin n_fail++; $display("FAIL bp_order[%0d] got v=%b d=%h exp v=1 d=%h", got, bus.out_valid, obs, expect_out(ops[got])); end
        if (bus.out_valid) got++;
      end
      step(!c_taken, ops[2], 1'b1, a);
      if (a) c_taken = 1'b1;
    end
    n_checks++; if (got != 3 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_count got n=%0d v=%b exp n=3 v=0", got, bus.out_valid); end
  endtask
  task automatic test_back_to_back();
    logic a;
    op_t p = rand_op();
    step(1'b1, p, 1'b1, a);
    for (int i = 0; i < 8; i++) begin
      op_t n = rand_op();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_flow[%0d] got v=%b r=%b b=%b exp 1 1 1", i, bus.out_valid, bus.in_ready, bus.busy); end
      n_checks++; if (obs !== expect_out(p)) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, obs, expect_out(p)); end
      step(1'b1, n, 1'b1, a);
      p = n;
    end
    n_checks++; if (obs !== expect_out(p)) begin n_fail++; $display("FAIL b2b_last got=%h exp=%h", obs, expect_out(p)); end
    step(1'b0, '0, 1'b1, a);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask
  task automatic test_midreset();
    logic a;
    step(1'b1, rand_op(), 1'b0, a);
    step(1'b1, rand_op(), 1'b0, a);
    n_checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL mr_full got r=%b b=%b exp 0 1", bus.in_ready, bus.busy); end
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    rdy_m = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || obs !== 63'd0) begin n_fail++; $display("FAIL mr_cleared got v=%b b=%b r=%b d=%h exp 0 0 0 0", bus.out_valid, bus.busy, bus.in_ready, obs); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, a);
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_after[%0d] got v=%b r=%b exp v=0 r=1", i, bus.out_valid, bus.in_ready); end
    end
  endtask
  task automatic test_stability();
    logic a;
    logic [62:0] snap;
    op_t s = rand_op();
    step(1'b1, s, 1'b0, a);
    snap = obs;
    n_checks++; if (snap !== expect_out(s)) begin n_fail++; $display("FAIL stab_head got=%h exp=%h", snap, expect_out(s)); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_op(), 1'b0, a);
      n_checks++; if (bus.out_valid !== 1'b1 || obs !== snap) begin n_fail++; $display("FAIL stab_hold[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, obs, snap); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.out_valid !== (q.size() != 0) || (q.size() != 0 && obs !== expect_out(q[0]))) begin n_fail++; $display("FAIL stab_drain[%0d] got v=%b d=%h exp v=%b", i, bus.out_valid, obs, q.size() != 0); end
      step(1'b0, '0, 1'b1, a);
    end
  endtask
  task automatic test_random();
    logic a;
    for (int i = 0; i < 300; i++) begin
      n_checks++; if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== rdy_m) begin n_fail++; $display("FAIL rand_flow[%0d] got v=%b r=%b exp v=%b r=%b", i, bus.out_valid, bus.in_ready, q.size() != 0, rdy_m); end
      if (q.size() != 0) begin
        n_checks++; if (obs !== expect_out(q[0])) begin n_fail++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, obs, expect_out(q[0])); end
      end
      step(1'($urandom_range(0, 1)), rand_op(), 1'($urandom_range(0, 3) != 0), a);
    end
    repeat (3) step(1'b0, '0, 1'b1, a);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_drain got v=%b b=%b exp 0 0", bus.out_valid, bus.busy); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_midreset();
    test_stability();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
